// File: rtl/soc_mem_io_if.sv
// Core-to-memory bus: byte address, read strobe, byte write mask.
// master = core side, slave = memory/IO side.
interface soc_mem_io_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;

  modport master (
    output mem_addr,
    output mem_rstrb,
    output mem_wmask,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rstrb,
    input  mem_wmask,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/soc_mem_io.sv
// RAM plus IO page (LEDs, 8N1 UART TX, cycle counter) behind the core bus.
// Ports: clk_i, rst_i (sync, active-high), bus (slave), leds_o, uart_tx_o, uart_busy_o.
module soc_mem_io #(
  parameter int RAM_WORDS   = 1536,
  parameter     INIT_FILE   = "",
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic         clk_i,
  input  logic         rst_i,
  soc_mem_io_if.slave  bus,
  output logic [4:0]   leds_o,
  output logic         uart_tx_o,
  output logic         uart_busy_o
);

  localparam int IDX = $clog2(RAM_WORDS);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BW  = $clog2(CPB);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  logic [31:0] ram [RAM_WORDS];

  logic           io_sel;
  logic [3:0]     off;
  logic [IDX-1:0] idx;
  logic           in_range;
  logic           we;

  assign io_sel   = bus.mem_addr[22];
  assign off      = bus.mem_addr[5:2];
  assign idx      = bus.mem_addr[IDX+1:2];
  assign in_range = {1'b0, idx} < (IDX+1)'(RAM_WORDS);
  assign we       = |bus.mem_wmask;

  logic sel_ram;
  logic sel_led;
  logic sel_uart;
  logic sel_stat;
  logic sel_cyc;

  assign sel_ram  = !io_sel && in_range;
  assign sel_led  = io_sel && (off == 4'b0001);
  assign sel_uart = io_sel && (off == 4'b0010);
  assign sel_stat = io_sel && (off == 4'b0100);
  assign sel_cyc  = io_sel && (off == 4'b1000);

  logic       ram_we;
  logic       led_wr;
  logic       uart_wr;

  assign ram_we  = we && sel_ram;
  assign led_wr  = sel_led && bus.mem_wmask[0];
  assign uart_wr = sel_uart && bus.mem_wmask[0];

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.mem_wmask[k]) begin
          ram[idx][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
        end
      end
    end
  end

  logic [4:0]  leds_q;
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      leds_q   <= '0;
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (led_wr) begin
        leds_q <= bus.mem_wdata[4:0];
      end
    end
  end

  state_t        state_q;
  logic [9:0]    shift_q;
  logic [3:0]    bit_cnt_q;
  logic [BW-1:0] baud_cnt_q;
  logic          tx_q;
  logic          busy_q;

  // tx is registered, so it is loaded with the bit that shift[0]
  // will hold after the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (uart_wr) begin
            shift_q    <= {1'b1, bus.mem_wdata[7:0], 1'b0};
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 4'd9) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              shift_q   <= {1'b1, shift_q[9:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_rstrb) begin
      unique case (1'b1)
        sel_ram:  bus.mem_rdata = ram[idx];
        sel_led:  bus.mem_rdata = {27'b0, leds_q};
        sel_stat: bus.mem_rdata = {22'b0, busy_q, 9'b0};
        sel_cyc:  bus.mem_rdata = cycles_q;
        default:  bus.mem_rdata = '0;
      endcase
    end
  end

  assign leds_o      = leds_q;
  assign uart_tx_o   = tx_q;
  assign uart_busy_o = busy_q;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr, shift_q[0]};

endmodule
